// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receiver and transmitter.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: clocked state uses non-blocking assignments so both flops update
  // from their pre-edge values and the chain stays two stages deep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first; samples each bit near its centre and
// reports good bytes on o_RX_DV and bad stop bits on o_Frame_Err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_Frame_Err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_t        state, state_nxt;
  logic             rx_s;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             half_hit, bit_hit;
  logic             sample_data, sample_stop, cnt_clr, cnt_run;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (i_RX_Serial),
    .q   (rx_s)
  );

  assign half_hit = (clk_cnt == HALF_CNT);
  assign bit_hit  = (clk_cnt == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case statement can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!rx_s) state_nxt = START;
      START:   if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (bit_hit && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (bit_hit) state_nxt = rx_s ? CLEANUP : BREAK;
      CLEANUP: state_nxt = IDLE;
      BREAK:   if (rx_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_RX_Active = (state != IDLE);
    sample_data = (state == DATA) && bit_hit;
    sample_stop = (state == STOP) && bit_hit;
    cnt_run     = (state == START) || (state == DATA) || (state == STOP);
    cnt_clr     = (state_nxt != state) || sample_data;
  end

  // The shift register is a handful of flops, so it is reset like the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      o_RX_Byte   <= '0;
      o_RX_DV     <= 1'b0;
      o_Frame_Err <= 1'b0;
    end else begin
      if (cnt_clr || !cnt_run) clk_cnt <= '0;
      else                     clk_cnt <= clk_cnt + 1'b1;

      if (state == IDLE)    bit_idx <= '0;
      else if (sample_data) bit_idx <= bit_idx + 3'd1;

      if (sample_data) shift[bit_idx] <= rx_s;

      if (sample_stop && rx_s) o_RX_Byte <= shift;

      o_RX_DV     <= sample_stop && rx_s;
      o_Frame_Err <= sample_stop && !rx_s;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 8 clocks per bit: stimulus queues the
// expected pulses, a monitor pops and compares them as the DUT reports.
module tb_uart_rx;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_Frame_Err;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_RX_Serial (rx),
    .o_RX_DV     (o_RX_DV),
    .o_RX_Byte   (o_RX_Byte),
    .o_RX_Active (o_RX_Active),
    .o_Frame_Err (o_Frame_Err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         total = 0;
  int         bad = 0;
  int         dv_cnt = 0;
  int         err_cnt = 0;
  int         both_cnt = 0;
  int         hold_viol = 0;
  int         since_dv = -1;
  logic [7:0] prev_byte = 8'h00;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (rst) begin
      since_dv  = -1;
      prev_byte = o_RX_Byte;
    end else begin
      if (o_RX_DV && o_Frame_Err) both_cnt++;
      if (o_RX_Byte !== prev_byte && !o_RX_DV) hold_viol++;
      prev_byte = o_RX_Byte;
      if (since_dv >= 0) begin
        since_dv++;
        if (since_dv == 2) begin
          check("active_low_after_dv", o_RX_Active, 0);
          since_dv = -1;
        end
      end
      if (o_RX_DV || o_Frame_Err) begin
        if (o_RX_DV) begin
          dv_cnt++;
          since_dv = 0;
        end
        if (o_Frame_Err) err_cnt++;
        check("pulse_was_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("pulse_kind_is_err", o_Frame_Err, e.is_err);
          check("rx_byte", o_RX_Byte, e.data);
        end
      end
    end
  end

  task automatic expect_dv(input logic [7:0] d);
    sb.push_back('{is_err: 1'b0, data: d});
    last_good = d;
  endtask

  task automatic expect_err();
    sb.push_back('{is_err: 1'b1, data: last_good});
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // jit_edge k (1..9) moves the edge starting bit k by jit_delta cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int jit_edge, input int jit_delta);
    logic [9:0] bits;
    int         dur[10];
    bits = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) dur[i] = CPB;
    if (jit_edge > 0) begin
      dur[jit_edge-1] += jit_delta;
      dur[jit_edge]   -= jit_delta;
    end
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat (dur[i]) @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_byte", o_RX_Byte, 8'h00);
    check("reset_dv", o_RX_DV, 0);
    check("reset_ferr", o_Frame_Err, 0);
    check("reset_active", o_RX_Active, 0);
    rst = 1'b0;
    idle(10);
    check("idle_active", o_RX_Active, 0);

    // Clean frame.
    expect_dv(8'hA5);
    send_frame(8'hA5, 1'b1, 0, 0);
    idle(20);

    // Bad stop bit followed by a long break; byte must keep 0xA5.
    expect_err();
    send_frame(8'h3C, 1'b0, 0, 0);
    rx = 1'b0;
    repeat (20) @(negedge clk);
    check("break_active_mid", o_RX_Active, 1);
    repeat (20) @(negedge clk);
    check("break_active_end", o_RX_Active, 1);
    idle(30);
    check("break_released", o_RX_Active, 0);
    check("byte_kept_after_ferr", o_RX_Byte, 8'hA5);

    // Two-cycle glitch on an idle line.
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("glitch_in_start", o_RX_Active, 1);
    idle(10);
    check("glitch_rejected", o_RX_Active, 0);

    // Back-to-back frames without an idle gap.
    expect_dv(8'h00);
    expect_dv(8'hFF);
    send_frame(8'h00, 1'b1, 0, 0);
    send_frame(8'hFF, 1'b1, 0, 0);
    idle(20);

    // Reset in the middle of data bit 4 of 0x5A.
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = (i % 2 == 1);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_active_in_reset", o_RX_Active, 0);
    rst = 1'b0;
    last_good = 8'h00;
    idle(30);
    check("abort_idle", o_RX_Active, 0);
    check("abort_byte_cleared", o_RX_Byte, 8'h00);
    expect_dv(8'h81);
    send_frame(8'h81, 1'b1, 0, 0);
    idle(20);
    check("byte_after_abort", o_RX_Byte, 8'h81);

    // Baud jitter: one edge late by 2, then another edge early by 2.
    expect_dv(8'h55);
    send_frame(8'h55, 1'b1, 4, 2);
    idle(20);
    expect_dv(8'h55);
    send_frame(8'h55, 1'b1, 5, -2);
    idle(20);
    check("byte_after_jitter", o_RX_Byte, 8'h55);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    check("dv_pulse_count", dv_cnt, 6);
    check("ferr_pulse_count", err_cnt, 1);
    check("dv_and_ferr_together", both_cnt, 0);
    check("byte_changed_without_dv", hold_viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
